// File: rtl/pdn_rail_sequencer.sv
// pdn_rail_sequencer: ordered power-up/down of NUM_RAILS supply rails with power-good checking and fault shutdown
module pdn_rail_sequencer #(
  parameter int NUM_RAILS   = 8,
  parameter int IDX_W       = 5,
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 100,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwr_up_req,
  input  logic                 pwr_dn_req,
  input  logic                 fault_clr,
  input  logic [NUM_RAILS-1:0] rail_pg,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 all_good,
  output logic                 busy,
  output logic                 fault,
  output logic [IDX_W-1:0]     fault_rail
);
  typedef enum logic [2:0] {OFF, UP_WAIT, UP_SETTLE, ON, DN_WAIT, DN_SETTLE, FAULT} state_t;
  localparam logic [NUM_RAILS-1:0] ONE = NUM_RAILS'(1);
  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, fault_rail_q, fault_rail_d, mon_idx;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d, cur, bad;
  logic                 all_good_q, busy_q, fault_q, trans, pg_cur, tmo, stl;
  // Rail monitor: enabled rails that lost power-good, excluding the rail being stepped
  always_comb begin
    trans   = state_q inside {UP_WAIT, UP_SETTLE, DN_WAIT, DN_SETTLE};
    cur     = ONE << idx_q;
    bad     = (trans || state_q == ON) ? rail_en_q & ~rail_pg & (trans ? ~cur : '1) : '0;
    pg_cur  = |(rail_pg & cur);
    tmo     = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
    stl     = cnt_q == CNT_W'(SETTLE_CYC - 1);
    mon_idx = '0;
    for (int j = NUM_RAILS - 1; j >= 0; j--)
      if (bad[j]) mon_idx = IDX_W'(j);
  end
  // Sequencing decisions; a monitor fault overrides every other transition
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rail_en_d    = rail_en_q;
    fault_rail_d = fault_rail_q;
    cnt_d        = trans ? cnt_q + 1'b1 : '0;
    if (|bad) begin
      state_d      = FAULT;
      fault_rail_d = mon_idx;
    end else begin
      case (state_q)
        OFF: if (pwr_up_req && !pwr_dn_req) begin
          state_d   = UP_WAIT;
          idx_d     = '0;
          rail_en_d = ONE;
        end
        UP_WAIT: if (pwr_dn_req) begin
          state_d   = DN_WAIT;
          rail_en_d = rail_en_q & ~cur;
        end else if (pg_cur) state_d = UP_SETTLE;
        else if (tmo) begin
          state_d      = FAULT;
          fault_rail_d = idx_q;
        end
        UP_SETTLE: if (pwr_dn_req) begin
          state_d   = DN_WAIT;
          rail_en_d = rail_en_q & ~cur;
        end else if (stl && idx_q == IDX_W'(NUM_RAILS - 1)) state_d = ON;
        else if (stl) begin
          state_d   = UP_WAIT;
          idx_d     = idx_q + 1'b1;
          rail_en_d = rail_en_q | (cur << 1);
        end
        ON: if (pwr_dn_req) begin
          state_d   = DN_WAIT;
          idx_d     = IDX_W'(NUM_RAILS - 1);
          rail_en_d = rail_en_q & ~(ONE << (NUM_RAILS - 1));
        end
        DN_WAIT: if (!pg_cur) state_d = DN_SETTLE;
        else if (tmo) begin
          state_d      = FAULT;
          fault_rail_d = idx_q;
        end
        DN_SETTLE: if (stl && idx_q == '0) state_d = OFF;
        else if (stl) begin
          state_d   = DN_WAIT;
          idx_d     = idx_q - 1'b1;
          rail_en_d = rail_en_q & ~(cur >> 1);
        end
        FAULT: if (fault_clr && !pwr_up_req) begin
          state_d = OFF;
          idx_d   = '0;
        end
        default: state_d = OFF;
      endcase
    end
    if (state_d == FAULT) rail_en_d = '0;
    if (state_d != state_q) cnt_d = '0;
  end
  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      rail_en_q    <= '0;
      fault_rail_q <= '0;
      all_good_q   <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rail_en_q    <= rail_en_d;
      fault_rail_q <= fault_rail_d;
      all_good_q   <= state_d == ON;
      busy_q       <= state_d inside {UP_WAIT, UP_SETTLE, DN_WAIT, DN_SETTLE};
      fault_q      <= state_d == FAULT;
    end
  end
  assign rail_en    = rail_en_q;
  assign all_good   = all_good_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_rail = fault_rail_q;
endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// tb_pdn_rail_sequencer: vector table, directed corner sequences and random run against a rail-level model
module tb_pdn_rail_sequencer;
  localparam int N = 4, ST = 4, TO = 8, IW = 5;
  logic clk = 0, rst_n = 0, up = 0, dn = 0, clr = 0;
  logic [N-1:0] pg_q = '0, kill = '0, rail_pg, rail_en;
  logic all_good, busy, fault;
  logic [IW-1:0] fault_rail;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  // power-good follows enable through one flop, gated by injected faults
  always @(posedge clk) pg_q <= rail_en;
  assign rail_pg = pg_q & ~kill;

  pdn_rail_sequencer #(.NUM_RAILS(N), .IDX_W(IW), .CNT_W(16), .SETTLE_CYC(ST), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_up_req(up), .pwr_dn_req(dn), .fault_clr(clr),
    .rail_pg(rail_pg), .rail_en(rail_en), .all_good(all_good), .busy(busy),
    .fault(fault), .fault_rail(fault_rail));

  // reference model: which rail is stepping, how long it has been waiting, which rails are lit
  typedef enum {IDLE, RISE, HOLD_UP, UP, FALL, HOLD_DN, TRIP} mode_t;
  mode_t mode;
  int rail, age, m_frail;
  logic [N-1:0] m_en;

  task automatic model_reset();
    mode = IDLE; rail = 0; age = 0; m_en = '0; m_frail = 0;
  endtask

  task automatic model_step(input logic u, input logic d, input logic c, input logic [N-1:0] pg);
    mode_t old;
    int trip;
    bit moving;
    old = mode;
    trip = -1;
    moving = mode inside {RISE, HOLD_UP, FALL, HOLD_DN};
    if (moving || mode == UP)
      for (int j = N - 1; j >= 0; j--)
        if (m_en[j] && !pg[j] && !(moving && j == rail)) trip = j;
    if (trip >= 0) begin
      mode = TRIP; m_frail = trip;
    end else begin
      case (mode)
        IDLE: if (u && !d) begin mode = RISE; rail = 0; m_en[0] = 1'b1; end
        RISE:
          if (d) begin mode = FALL; m_en[rail] = 1'b0; end
          else if (pg[rail]) mode = HOLD_UP;
          else if (age + 1 >= TO) begin mode = TRIP; m_frail = rail; end
        HOLD_UP:
          if (d) begin mode = FALL; m_en[rail] = 1'b0; end
          else if (age + 1 >= ST) begin
            if (rail == N - 1) mode = UP;
            else begin rail++; m_en[rail] = 1'b1; mode = RISE; end
          end
        UP: if (d) begin mode = FALL; rail = N - 1; m_en[rail] = 1'b0; end
        FALL:
          if (!pg[rail]) mode = HOLD_DN;
          else if (age + 1 >= TO) begin mode = TRIP; m_frail = rail; end
        HOLD_DN:
          if (age + 1 >= ST) begin
            if (rail == 0) mode = IDLE;
            else begin rail--; m_en[rail] = 1'b0; mode = FALL; end
          end
        TRIP: if (c && !u) mode = IDLE;
        default: ;
      endcase
    end
    if (mode == TRIP) m_en = '0;
    age = (mode != old) ? 0 : age + 1;
  endtask

  task automatic tick(input int n);
    logic [N-1:0] snap;
    for (int i = 0; i < n; i++) begin
      snap = pg_q & ~kill;
      @(posedge clk);
      model_step(up, dn, clr, snap);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string t, input logic [N-1:0] e_en, input logic e_good,
                           input logic e_busy, input logic e_flt, input int e_fr);
    chk({t, ".rail_en"}, rail_en, e_en);
    chk({t, ".all_good"}, all_good, e_good);
    chk({t, ".busy"}, busy, e_busy);
    chk({t, ".fault"}, fault, e_flt);
    chk({t, ".fault_rail"}, fault_rail, e_fr);
  endtask

  typedef struct {
    logic up, dn, clr;
    logic [N-1:0] kill;
    int cyc;
    logic [N-1:0] en;
    logic good, busy, flt;
    int frail;
  } vec_t;
  vec_t tbl[21];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic hi_seen;
    int regime;
    logic [N-1:0] sticky;
    tbl[0]  = '{1, 0, 0, 4'b0000, 1,  4'b0001, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 4'b0000, 6,  4'b0011, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 4'b0000, 6,  4'b0111, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 4'b0000, 6,  4'b1111, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 4'b0000, 5,  4'b1111, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 4'b0000, 1,  4'b1111, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 4'b0000, 3,  4'b1111, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 4'b0000, 1,  4'b0111, 0, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 4'b0000, 6,  4'b0011, 0, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 4'b0000, 6,  4'b0001, 0, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 4'b0000, 6,  4'b0000, 0, 1, 0, 0};
    tbl[11] = '{0, 1, 0, 4'b0000, 5,  4'b0000, 0, 1, 0, 0};
    tbl[12] = '{0, 1, 0, 4'b0000, 1,  4'b0000, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 0, 4'b0000, 2,  4'b0000, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 4'b0100, 1,  4'b0001, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 4'b0100, 12, 4'b0111, 0, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 4'b0100, 7,  4'b0111, 0, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 4'b0100, 1,  4'b0000, 0, 0, 1, 2};
    tbl[18] = '{1, 0, 1, 4'b0100, 2,  4'b0000, 0, 0, 1, 2};
    tbl[19] = '{0, 0, 1, 4'b0100, 1,  4'b0000, 0, 0, 0, 2};
    tbl[20] = '{0, 0, 0, 4'b0000, 2,  4'b0000, 0, 0, 0, 2};

    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset", 4'b0000, 0, 0, 0, 0);
    rst_n = 1;

    for (int i = 0; i < 21; i++) begin
      up = tbl[i].up; dn = tbl[i].dn; clr = tbl[i].clr; kill = tbl[i].kill;
      tick(tbl[i].cyc);
      check_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].good, tbl[i].busy, tbl[i].flt, tbl[i].frail);
    end
    up = 0; dn = 0; clr = 0; kill = '0;

    up = 1; tick(1); up = 0; tick(24);
    check_all("mon_on", 4'b1111, 1, 0, 0, 2);
    kill = 4'b1010; tick(1);
    check_all("mon_trip", 4'b0000, 0, 0, 1, 1);
    kill = '0; clr = 1; tick(1); clr = 0;
    check_all("mon_clr", 4'b0000, 0, 0, 0, 1);

    up = 1; tick(1); up = 0; tick(9);
    dn = 1; tick(1);
    check_all("abort_r1", 4'b0001, 0, 1, 0, 1);
    hi_seen = 0;
    for (int i = 0; i < 6; i++) begin tick(1); hi_seen |= |rail_en[3:2]; end
    check_all("abort_r0", 4'b0000, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin tick(1); hi_seen |= |rail_en[3:2]; end
    check_all("abort_off", 4'b0000, 0, 0, 0, 1);
    chk("abort_upper_rails", hi_seen, 0);
    dn = 0;

    up = 1; tick(1); up = 0; tick(6);
    chk("rst_pre.rail_en", rail_en, 4'b0011);
    #2 rst_n = 0;
    #1 check_all("rst_async", 4'b0000, 0, 0, 0, 0);
    model_reset();
    up = 1; dn = 1;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    tick(3);
    check_all("rst_both_req", 4'b0000, 0, 0, 0, 0);
    up = 0; dn = 0;

    regime = 0; sticky = '0;
    for (int c = 0; c < 800; c++) begin
      if (c % 32 == 0) regime = int'($urandom % 3);
      dn = (regime == 1) ? 1'b1 : (regime == 0) ? 1'b0 : ($urandom % 8 == 0);
      up = ($urandom % 4 != 0);
      clr = ($urandom % 6 == 0);
      if ($urandom % 150 == 0) sticky = N'($urandom);
      if ($urandom % 40 == 0) sticky = '0;
      kill = sticky | (($urandom % 40 == 0) ? N'($urandom) : '0);
      tick(1);
      check_all($sformatf("rand%0d", c), m_en, mode == UP,
                mode inside {RISE, HOLD_UP, FALL, HOLD_DN}, mode == TRIP, m_frail);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
